// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the single-master Wishbone interconnect.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package wb_bus_pkg;

    // Interconnect grant state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        UERR  = 2'd2
    } state_t;

    // Outstanding counter is sized for the largest legal MAX_OUT (15).
    localparam int MAX_OUT_LIMIT = 15;
    localparam int OUT_W         = $clog2(MAX_OUT_LIMIT + 1);

    // Watchdog counter width; wide enough for any int TIMEOUT.
    localparam int WD_W          = 32;

    // Widest address the match helper handles; callers zero-extend.
    localparam int ADR_MAX       = 64;

    // A slave matches when the masked address equals its masked base.
    function automatic logic slave_match(input logic [ADR_MAX-1:0] adr,
                                         input logic [ADR_MAX-1:0] base,
                                         input logic [ADR_MAX-1:0] mask);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Address decoder: one-hot slave match, its index and a hit flag; lowest index wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module wb_addr_decoder
    import wb_bus_pkg::*;
#(
    parameter int              NS         = 6,
    parameter int              AW         = 32,
    parameter int              IDX_W      = (NS > 1) ? $clog2(NS) : 1,
    parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '1
) (
    input  logic [AW-1:0]    adr,
    output logic [NS-1:0]    match,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    // Scan from the top down so the lowest matching index overwrites the rest.
    always_comb begin
        match = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (slave_match(ADR_MAX'(adr),
                            ADR_MAX'(SLAVE_ADDR[i*AW +: AW]),
                            ADR_MAX'(SLAVE_MASK[i*AW +: AW]))) begin
                match    = '0;
                match[i] = 1'b1;
                idx      = IDX_W'(i);
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_bus_decoder.sv
// Single-master to NS-slave pipelined Wishbone interconnect with ordering, unmapped-error and watchdog.
// Latency: zero-cycle request/response passthrough once granted; unmapped error one cycle after acceptance.
// Backpressure: slave stall, outstanding limit and slave-switch ordering all surface as m_stall_o.
module wb_bus_decoder
    import wb_bus_pkg::*;
#(
    parameter int               NS         = 6,
    parameter int               AW         = 32,
    parameter int               DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_ADDR = '0,
    parameter logic [NS*AW-1:0] SLAVE_MASK = '1,
    parameter int               MAX_OUT    = 4,
    parameter int               TIMEOUT    = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             m_cyc_i,
    input  logic             m_stb_i,
    input  logic             m_we_i,
    input  logic [AW-1:0]    m_adr_i,
    input  logic [DW-1:0]    m_dat_i,
    input  logic [DW/8-1:0]  m_sel_i,
    output logic             m_ack_o,
    output logic             m_err_o,
    output logic             m_stall_o,
    output logic [DW-1:0]    m_dat_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    output logic             s_we_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [DW/8-1:0]  s_sel_o,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS-1:0]    s_err_i,
    input  logic [NS-1:0]    s_stall_i,
    input  logic [NS*DW-1:0] s_dat_i,
    output logic             timeout_o
);

    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

    logic [NS-1:0]    match;
    logic [IDX_W-1:0] idx;
    logic             hit;

    state_t           state, state_nx;
    logic [IDX_W-1:0] gnt, gnt_nx;
    logic [OUT_W-1:0] outst;
    logic [WD_W-1:0]  wdog;

    logic cyc, req, busy, full, accept, resp, clr;

    wb_addr_decoder #(
        .NS         (NS),
        .AW         (AW),
        .IDX_W      (IDX_W),
        .SLAVE_ADDR (SLAVE_ADDR),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_dec (
        .adr   (m_adr_i),
        .match (match),
        .idx   (idx),
        .hit   (hit)
    );

    // Reset gates the master cycle so every slave/master control output is low while it is held.
    assign cyc  = m_cyc_i & wb_rst_ni;
    assign req  = cyc & m_stb_i;
    assign busy = (outst != '0);
    assign full = (outst == OUT_W'(MAX_OUT));

    assign s_we_o  = m_we_i;
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;

    // Next-state, routing and response muxing for the grant FSM.
    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        s_cyc_o   = '0;
        s_stb_o   = '0;
        m_stall_o = 1'b0;
        m_ack_o   = 1'b0;
        m_err_o   = 1'b0;
        m_dat_o   = '0;
        timeout_o = 1'b0;
        accept    = 1'b0;
        resp      = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // Grant in the same cycle the request is decoded.
                        s_cyc_o   = match;
                        s_stb_o   = match;
                        m_stall_o = |(match & s_stall_i);
                        accept    = ~(|(match & s_stall_i));
                        state_nx  = GRANT;
                        gnt_nx    = idx;
                    end else begin
                        state_nx = UERR;
                    end
                end
            end
            UERR: begin
                m_err_o  = cyc;
                state_nx = IDLE;
                if (req) begin
                    // Another unmapped strobe keeps the error pipeline running;
                    // a mapped one waits until this error has gone out.
                    if (hit) m_stall_o = 1'b1;
                    else     state_nx  = UERR;
                end
            end
            GRANT: begin
                if (!cyc) begin
                    clr      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    // Responses with nothing outstanding are stale and dropped.
                    resp    = busy & (s_ack_i[gnt] | s_err_i[gnt]);
                    m_ack_o = busy & s_ack_i[gnt];
                    m_err_o = busy & s_err_i[gnt];
                    m_dat_o = s_dat_i[gnt*DW +: DW];
                    if (TIMEOUT != 0 && busy && !resp && wdog == WD_W'(TIMEOUT - 1)) begin
                        // Hung slave: error the master, drop the slave cycle for a cycle.
                        m_err_o   = 1'b1;
                        timeout_o = 1'b1;
                        m_stall_o = req;
                        clr       = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        s_cyc_o[gnt] = 1'b1;
                        if (req) begin
                            if (hit && idx == gnt) begin
                                // A response this cycle frees a slot for a same-cycle accept.
                                if (full && !resp) begin
                                    m_stall_o = 1'b1;
                                end else begin
                                    s_stb_o[gnt] = 1'b1;
                                    m_stall_o    = s_stall_i[gnt];
                                    accept       = ~s_stall_i[gnt];
                                end
                            end else begin
                                // Different target: hold it off until the pipe drains to keep order.
                                m_stall_o = 1'b1;
                                if (!busy) state_nx = IDLE;
                            end
                        end else if (!busy) begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            gnt   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
        end
    end

    // Outstanding count: accept and response in one cycle cancel out.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)             outst <= '0;
        else if (clr)               outst <= '0;
        else if (accept && !resp)   outst <= outst + OUT_W'(1);
        else if (!accept && resp)   outst <= outst - OUT_W'(1);
    end

    // Watchdog counts silent cycles while anything is outstanding.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)                 wdog <= '0;
        else if (clr || resp || !busy)  wdog <= '0;
        else                            wdog <= wdog + WD_W'(1);
    end

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Self-checking bench for wb_bus_decoder: decode table plus directed multi-cycle sequences.
module tb_wb_bus_decoder;

    localparam int NS = 6;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    // Slave 5 overlaps slave 2 (0x2xxxxxxx) so lowest-index priority is visible.
    localparam logic [NS*AW-1:0] ADDRS = {32'h20000000, 32'h40000000, 32'h30000000,
                                          32'h20000000, 32'h00000000, 32'h10000000};
    localparam logic [NS*AW-1:0] MASKS = {32'hF0000000, 32'hFF000000, 32'hFF000000,
                                          32'hFF000000, 32'hFF000000, 32'hFF000000};

    logic            clk;
    logic            rst_n;
    logic            m_cyc, m_stb, m_we;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_wdat;
    logic [SW-1:0]   m_sel;
    logic            m_ack, m_err, m_stall;
    logic [DW-1:0]   m_rdat;
    logic [NS-1:0]   s_cyc, s_stb;
    logic            s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic [SW-1:0]   s_sel;
    logic [NS-1:0]   s_ack, s_err, s_stall;
    logic [NS*DW-1:0] s_rdat;
    logic            tmo;

    int tests = 0;
    int fails = 0;

    wb_bus_decoder #(
        .NS (NS), .AW (AW), .DW (DW),
        .SLAVE_ADDR (ADDRS), .SLAVE_MASK (MASKS),
        .MAX_OUT (4), .TIMEOUT (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_wdat),
        .m_sel_i   (m_sel),
        .m_ack_o   (m_ack),
        .m_err_o   (m_err),
        .m_stall_o (m_stall),
        .m_dat_o   (m_rdat),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_sel_o   (s_sel),
        .s_ack_i   (s_ack),
        .s_err_i   (s_err),
        .s_stall_i (s_stall),
        .s_dat_i   (s_rdat),
        .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [5:0]  stall_in;
        logic [5:0]  exp_stb;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic [31:0] adr, input logic we);
        m_cyc = cyc;
        m_stb = stb;
        m_adr = adr;
        m_we  = we;
    endtask

    task automatic set_dat(input int k, input logic [31:0] val);
        s_rdat[k*DW +: DW] = val;
    endtask

    logic [16:0] tmo_seen, err_seen, c4_seen;
    logic [5:0]  err6, busy6;
    logic [3:0]  bits4;
    logic [2:0]  bits3;

    initial begin
        vecs[0] = '{32'h00000010, 6'b000000, 6'b000010, 1'b0};
        vecs[1] = '{32'h10000004, 6'b000000, 6'b000001, 1'b0};
        vecs[2] = '{32'h20000000, 6'b000000, 6'b000100, 1'b0};
        vecs[3] = '{32'h21000000, 6'b000000, 6'b100000, 1'b0};
        vecs[4] = '{32'h30000000, 6'b000000, 6'b001000, 1'b0};
        vecs[5] = '{32'h40000000, 6'b000000, 6'b010000, 1'b0};
        vecs[6] = '{32'h07000000, 6'b000000, 6'b000000, 1'b0};
        vecs[7] = '{32'hFF000000, 6'b000000, 6'b000000, 1'b0};
        vecs[8] = '{32'h30000000, 6'b001000, 6'b001000, 1'b1};
        vecs[9] = '{32'h30000000, 6'b000001, 6'b001000, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        m_wdat = '0; m_sel = '0;
        s_ack = '0; s_err = '0; s_stall = '0; s_rdat = '0;

        // Reset state, then a mapped request held during reset must not reach a slave.
        @(negedge clk); #1;
        check("reset_outputs", 64'({s_cyc, s_stb, m_ack, m_err, tmo, m_stall}), 64'(0));
        drive(1'b1, 1'b1, 32'h00000010, 1'b0); #1;
        check("reset_gates_req", 64'({s_cyc, s_stb, m_stall}), 64'(0));
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0); rst_n = 1'b1;

        // Decode table: routing, priority, unmapped and stall passthrough (dropped before the edge).
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_stall = vecs[i].stall_in;
            drive(1'b1, 1'b1, vecs[i].adr, 1'b0);
            #1;
            check($sformatf("decode_vec%0d", i),
                  64'({s_stb, s_cyc, m_stall, s_adr}),
                  64'({vecs[i].exp_stb, vecs[i].exp_stb, vecs[i].exp_stall, vecs[i].adr}));
            #1;
            drive(1'b0, 1'b0, 32'h0, 1'b0);
            s_stall = '0;
        end

        // Single read to slave 1 acked two cycles later.
        @(negedge clk); drive(1'b1, 1'b1, 32'h00000100, 1'b0); #1;
        check("t1_route", 64'({s_cyc, s_stb, m_stall}), 64'({6'b000010, 6'b000010, 1'b0}));
        @(negedge clk); drive(1'b1, 1'b0, 32'h00000100, 1'b0); #1;
        check("t1_no_early_ack", 64'({m_ack, s_cyc}), 64'({1'b0, 6'b000010}));
        @(negedge clk); s_ack[1] = 1'b1; set_dat(1, 32'hDEADBEEF); #1;
        check("t1_ack_data", 64'({m_ack, m_rdat, s_cyc}), 64'({1'b1, 32'hDEADBEEF, 6'b000010}));
        @(negedge clk); s_ack = '0; #1;
        check("t1_ack_once", 64'(m_ack), 64'(0));
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Four pipelined writes to slave 2 fill the outstanding window.
        m_wdat = 32'hCAFE0000; m_sel = 4'hF;
        bits4 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b1, 1'b1, 32'h20000000 | 32'(i * 4), 1'b1); #1;
            bits4[i] = m_stall | (s_stb != 6'b000100);
        end
        check("t2_four_accepted", 64'(bits4), 64'(0));
        @(negedge clk); #1;
        check("t2_fifth_stalls", 64'({m_stall, s_stb}), 64'({1'b1, 6'b000000}));
        @(negedge clk); s_ack[2] = 1'b1; #1;
        check("t2_ack_frees_slot", 64'({m_stall, s_stb, m_ack}), 64'({1'b0, 6'b000100, 1'b1}));
        check("t2_broadcast", 64'({s_we, s_wdat, s_sel}), 64'({1'b1, 32'hCAFE0000, 4'hF}));
        @(negedge clk); s_ack = '0; #1;
        check("t2_still_full", 64'(m_stall), 64'(1));
        bits4 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 32'h20000000, 1'b1); s_ack[2] = 1'b1; #1;
            bits4[i] = m_ack;
        end
        check("t2_drain_acks", 64'(bits4), 64'(4'b1111));
        @(negedge clk); #1;
        check("t2_stale_ack_dropped", 64'(m_ack), 64'(0));
        @(negedge clk); s_ack = '0; drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Unmapped read: error one cycle after acceptance, no slave strobe.
        bits3 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b1, (i == 0), 32'h07000000, 1'b0); #1;
            bits3[i] = m_err;
            if (i == 0) check("t3_accept", 64'({m_stall, s_stb, s_cyc}), 64'(0));
        end
        check("t3_err_timing", 64'(bits3), 64'(3'b010));
        err6 = '0; busy6 = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(1'b1, (i < 3), 32'h07000000, 1'b0); #1;
            err6[i]  = m_err;
            busy6[i] = m_stall | (|s_stb);
        end
        check("t3_b2b_errs", 64'(err6), 64'(6'b001110));
        check("t3_b2b_no_stall", 64'(busy6), 64'(0));
        @(negedge clk); drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Slave 4 never answers: abort on the 16th cycle after acceptance.
        @(negedge clk); drive(1'b1, 1'b1, 32'h40000000, 1'b0); #1;
        check("t4_route", 64'(s_stb), 64'(6'b010000));
        tmo_seen = '0; err_seen = '0; c4_seen = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 32'h40000000, 1'b0); #1;
            tmo_seen[i] = tmo;
            err_seen[i] = m_err;
            c4_seen[i]  = s_cyc[4];
        end
        check("t4_timeout_pulse", 64'(tmo_seen), 64'(17'h10000));
        check("t4_err_pulse", 64'(err_seen), 64'(17'h10000));
        check("t4_cyc_dropped", 64'(c4_seen), 64'(17'h0FFFE));
        @(negedge clk); drive(1'b1, 1'b1, 32'h10000000, 1'b0); #1;
        check("t4_next_route", 64'({s_cyc, s_stb, m_stall}), 64'({6'b000001, 6'b000001, 1'b0}));
        @(negedge clk); drive(1'b1, 1'b0, 32'h10000000, 1'b0); s_ack[0] = 1'b1; set_dat(0, 32'h12345678); #1;
        check("t4_next_ack", 64'({m_ack, m_err, tmo, m_rdat}), 64'({1'b1, 1'b0, 1'b0, 32'h12345678}));
        @(negedge clk); s_ack = '0; drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Ordering: slave 3 request waits for the slave 0 read to complete.
        @(negedge clk); drive(1'b1, 1'b1, 32'h10000000, 1'b0); #1;
        check("t5_first_route", 64'(s_stb), 64'(6'b000001));
        bits3 = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b1, 1'b1, 32'h30000000, 1'b0); #1;
            bits3[i] = m_stall & (s_stb == 6'b000000);
        end
        check("t5_held_off", 64'(bits3), 64'(3'b011));
        @(negedge clk); s_ack[0] = 1'b1; set_dat(0, 32'hAAAA0000); #1;
        check("t5_first_resp", 64'({m_ack, m_rdat, m_stall, s_stb}), 64'({1'b1, 32'hAAAA0000, 1'b1, 6'b000000}));
        @(negedge clk); s_ack = '0; #1;
        check("t5_switch_cycle", 64'({m_stall, s_stb, m_ack}), 64'({1'b1, 6'b000000, 1'b0}));
        @(negedge clk); #1;
        check("t5_second_route", 64'({m_stall, s_stb, s_cyc}), 64'({1'b0, 6'b001000, 6'b001000}));
        @(negedge clk); drive(1'b1, 1'b0, 32'h30000000, 1'b0); s_ack[3] = 1'b1; set_dat(3, 32'hBBBB0003); #1;
        check("t5_second_resp", 64'({m_ack, m_rdat}), 64'({1'b1, 32'hBBBB0003}));
        @(negedge clk); s_ack = '0; drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset mid-transaction, then a late ack after release.
        @(negedge clk); drive(1'b1, 1'b1, 32'h00000200, 1'b0);
        @(negedge clk); rst_n = 1'b0; s_ack[1] = 1'b1; #1;
        check("t6_reset_mid", 64'({s_cyc, s_stb, m_ack, m_err, tmo, m_stall}), 64'(0));
        @(negedge clk); rst_n = 1'b1; drive(1'b1, 1'b0, 32'h00000200, 1'b0); #1;
        check("t6_reset_late_ack", 64'({m_ack, s_cyc}), 64'(0));
        @(negedge clk); s_ack = '0; drive(1'b0, 1'b0, 32'h0, 1'b0);

        // Master drops cyc mid-transaction, then a late ack.
        @(negedge clk); drive(1'b1, 1'b1, 32'h00000300, 1'b0); #1;
        check("t6_cyc_route", 64'(s_stb), 64'(6'b000010));
        @(negedge clk); drive(1'b0, 1'b0, 32'h00000300, 1'b0); s_ack[1] = 1'b1; #1;
        check("t6_cyc_drop", 64'({s_cyc, s_stb, m_ack, m_err}), 64'(0));
        @(negedge clk); drive(1'b1, 1'b0, 32'h00000300, 1'b0); #1;
        check("t6_cyc_late_ack", 64'({m_ack, s_cyc}), 64'(0));
        @(negedge clk); s_ack = '0; drive(1'b0, 1'b0, 32'h0, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_bus_decoder.md
Name: wb_bus_decoder

Overview:
Parametrised single-master to NS-slave pipelined Wishbone (B4, with stall) interconnect. It replaces fixed-size single-master bus instances in SoC tops. It adds per-slave address and mask decoding from parameters, outstanding-transaction tracking with ordering protection, bus-error generation for unmapped addresses, and a watchdog timeout that aborts hung slaves. It sits between the picorv32_wb master port and the peripheral slaves (ROM, RAM, UART, GPIO, measure unit).

Parameters:
NS, 6, number of slaves (1..16)
AW, 32, address width
DW, 32, data width; select width is DW/8
SLAVE_ADDR, {NS{AW'0}}, packed NS*AW base addresses; slave 0 is in the LSBs
SLAVE_MASK, {NS{AW'1}}, packed NS*AW masks; a slave matches when (adr & mask) == (base & mask)
MAX_OUT, 4, maximum outstanding (accepted, unacknowledged) requests (1..15)
TIMEOUT, 1024, cycles with no ack/err while requests are outstanding before abort; 0 disables the watchdog

Ports:
wb_clk_i  in  1  bus clock
wb_rst_ni  in  1  asynchronous active-low reset
m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable
m_adr_i  in  AW  master address
m_dat_i  in  DW  master write data
m_sel_i  in  DW/8  byte selects
m_ack_o, m_err_o, m_stall_o  out  1 each  master response and stall
m_dat_o  out  DW  read data
s_cyc_o, s_stb_o  out  NS  per-slave cycle and strobe
s_we_o, s_adr_o, s_dat_o, s_sel_o  out  1/AW/DW/DW/8  broadcast to all slaves
s_ack_i, s_err_i, s_stall_i  in  NS  per-slave response and stall
s_dat_i  in  NS*DW  packed read data
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async assert, sync deassert): state IDLE, grant none, outstanding=0, watchdog=0. All s_cyc_o/s_stb_o, m_ack_o, m_err_o and timeout_o are 0.
- Decode is combinational. The lowest-index matching slave wins. If no slave matches, the request is unmapped.
- States:
  - IDLE: no grant.
  - GRANT(k): granted slave k, held in a register.
  - UERR: an unmapped request is pending an error.
- IDLE transitions:
  - On m_cyc_i & m_stb_i to mapped slave k: grant k in the same cycle; s_stb_o[k] = m_stb_i combinationally.
  - On an unmapped request: accept it (m_stall_o=0), go to UERR, and assert m_err_o in the next cycle.
- In GRANT(k):
  - s_cyc_o[k] = m_cyc_i.
  - m_stall_o = s_stall_i[k] | (outstanding == MAX_OUT).
  - m_ack_o = s_ack_i[k]; m_err_o = s_err_i[k]; m_dat_o = s_dat_i[k].
  - Adds zero latency.
- Request to a different slave or an unmapped address while outstanding != 0: m_stall_o=1 and no s_stb_o is driven until outstanding reaches 0. The grant then switches in the next cycle. This preserves response order.
- Outstanding counter:
  - +1 on an accepted strobe (stb & !stall).
  - −1 on ack or err.
  - Accept and response in the same cycle: unchanged.
  - Never exceeds MAX_OUT; never underflows. Responses received with outstanding=0 are ignored and not forwarded.
- Grant release: go to IDLE when m_cyc_i=0, or when outstanding=0 and there is no strobe.
- m_cyc_i falling mid-transaction: all s_cyc_o drop in the same cycle, outstanding clears, and late slave acks are not forwarded.
- UERR:
  - m_err_o is a 1-cycle pulse, one cycle after acceptance.
  - Back-to-back unmapped strobes each produce one err pulse, pipelined.
  - A mapped request arriving in UERR stalls until the err is delivered.
- Watchdog:
  - Counts while outstanding > 0. Clears on any ack/err, and while outstanding=0.
  - When it reaches TIMEOUT: m_err_o=1 and timeout_o=1 for one cycle, s_cyc_o[k]=0 for one cycle, outstanding clears, go to IDLE.
  - An ack in the same cycle as expiry wins: no timeout.
- s_err_i[k] is passed through as m_err_o and decrements outstanding. It does not abort the cycle.

Decomposition:
- Package wb_bus_pkg holds:
  - the state enum (IDLE, GRANT, UERR);
  - the outstanding counter width localparam ($clog2(MAX_OUT+1));
  - the watchdog width localparam;
  - a function slave_match(adr, base, mask).
- Sub-module wb_addr_decoder (combinational) outputs a one-hot match[NS], an index, and a valid flag from m_adr_i and the packed parameter vectors. It is unit-testable on its own.

Test Plan:
1. Read to SLAVE_ADDR[1]=0x00000000 (mask 0xff000000), slave acks after 2 cycles with 0xDEADBEEF → m_ack_o pulses once, m_dat_o=0xDEADBEEF, only s_cyc_o[1] asserted.
2. 4 pipelined writes to slave 2 with MAX_OUT=4 and the slave withholding acks → 5th strobe sees m_stall_o=1; first ack → 5th is accepted in the same cycle and outstanding stays 4.
3. Read 0x07000000 (unmapped) → m_err_o pulses exactly 1 cycle after acceptance; no s_stb_o asserted. Three back-to-back unmapped strobes → three err pulses.
4. Slave 4 never acks, TIMEOUT=16 → m_err_o and timeout_o high on the 16th cycle after acceptance, s_cyc_o[4] low for 1 cycle, a following read to slave 0 completes normally.
5. Outstanding read on slave 0, then a strobe to slave 3 → stalled until slave 0 acks, then routed to slave 3; responses arrive in order.
6. wb_rst_ni asserted mid-transaction and m_cyc_i dropped mid-transaction (separately) → all outputs 0 immediately; a late s_ack_i is not forwarded.
